decode_issue_ctrl: RTL and testbench

- Decode-stage issue controller for the LoongArch core.
- Takes up to two decoded instruction packets per cycle from the per-format decoders (1RI20, 2RI12, 3R, …), after their per-slot merge. Buffers them in an in-order queue and issues up to two per cycle to dispatch.
- Serialises privileged/CSR instructions, converts "no decoder hit" into an INE exception, and clears on pipeline flush.

---
 rtl/decode_issue_ctrl_pkg.sv | 37 +++
 rtl/decode_queue.sv | 57 +++++
 rtl/decode_issue_ctrl.sv | 117 +++++++++++
 tb/tb_decode_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode-stage definitions: decoded packet layout, issue FSM encodings and
// the exception/ALU constants the decode path reuses.
package decode_issue_ctrl_pkg;

    localparam int DEC_PKT_W = 128;

    localparam logic [6:0] EXCEPTION_INE  = 7'h0d;
    localparam logic [7:0] ALU_NOP        = 8'h00;
    localparam logic [2:0] ALU_SEL_NOP    = 3'b000;
    localparam int         EXC_DECODE_BIT = 2;

    localparam logic [0:0] RUN       = 1'b0;
    localparam logic [0:0] WAIT_PRIV = 1'b1;

    // Field order is MSB first; pc occupies bits [31:0]. The immediate is
    // re-extracted from inst downstream, so it has no dedicated field.
    typedef struct packed {
        logic [7:0]  rsvd;
        logic [6:0]  decoder_exception_cause;
        logic [2:0]  is_exception;
        logic        inst_valid;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic        is_privilege;
        logic [4:0]  reg2_addr;
        logic        reg2_read_en;
        logic [4:0]  reg1_addr;
        logic        reg1_read_en;
        logic [4:0]  reg_write_addr;
        logic        reg_write_en;
        logic [2:0]  alusel;
        logic [7:0]  aluop;
        logic [31:0] inst;
        logic [31:0] pc;
    } decoded_pkt_t;

endpackage

// File: rtl/decode_queue.sv
// In-order circular decode buffer with two write and two read ports.
module decode_queue
    import decode_issue_ctrl_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int PKT_W  = DEC_PKT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [1:0]                wr_en,
    input  logic [PKT_W-1:0]          wr_pkt0,
    input  logic [PKT_W-1:0]          wr_pkt1,
    input  logic [1:0]                rd_cnt,
    output logic [PKT_W-1:0]          rd_pkt0,
    output logic [PKT_W-1:0]          rd_pkt1,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int AW = $clog2(QDEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [PKT_W-1:0] mem [QDEPTH];
    ptr_t rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
    cnt_t wr_cnt;

    assign wr_ptr1 = wr_ptr + 1'b1;
    assign rd_ptr1 = rd_ptr + 1'b1;
    assign wr_cnt  = cnt_t'(wr_en[0]) + cnt_t'(wr_en[1]);

    // Storage carries no reset; visibility is governed by count alone.
    always_ff @(posedge clk) begin
        if (wr_en[0]) mem[wr_ptr]  <= wr_pkt0;
        if (wr_en[1]) mem[wr_ptr1] <= wr_pkt1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + wr_cnt[AW-1:0];
            rd_ptr <= rd_ptr + ptr_t'(rd_cnt);
            count  <= count + wr_cnt - cnt_t'(rd_cnt);
        end
    end

    assign rd_pkt0 = (count != '0)        ? mem[rd_ptr]  : '0;
    assign rd_pkt1 = (count >= cnt_t'(2)) ? mem[rd_ptr1] : '0;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: buffers decoded pairs, issues up to two in order,
// serialises privileged ops and marks undecodable ones INE. DECODE_PERF_CNT_EN adds perf counters.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int PKT_W  = DEC_PKT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       in_valid,
    input  logic [PKT_W-1:0] in_pkt0,
    input  logic [PKT_W-1:0] in_pkt1,
    output logic             in_ready,
    output logic [1:0]       out_valid,
    output logic [PKT_W-1:0] out_pkt0,
    output logic [PKT_W-1:0] out_pkt1,
    input  logic [1:0]       out_ready,
    input  logic             priv_done,
    output logic             serial_busy
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_serial_stall
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [CW-1:0]    count;
    logic [PKT_W-1:0] q_pkt0, q_pkt1, wr_pkt0, wr_pkt1;
    decoded_pkt_t     head, second;
    logic [0:0]       state, state_nxt;
    logic [1:0]       enq_en, deq_cnt;
    logic             run_issue, head_alone, second_alone, accept0, accept1;

    function automatic decoded_pkt_t ine_rewrite(input decoded_pkt_t p);
        decoded_pkt_t r;
        r = p;
        if (!p.inst_valid) begin
            r.is_exception[EXC_DECODE_BIT] = 1'b1;
            r.decoder_exception_cause      = EXCEPTION_INE;
            r.reg_write_en                 = 1'b0;
            r.aluop                        = ALU_NOP;
            r.alusel                       = ALU_SEL_NOP;
        end
        return r;
    endfunction

    assign wr_pkt0 = ine_rewrite(decoded_pkt_t'(in_pkt0));
    assign wr_pkt1 = ine_rewrite(decoded_pkt_t'(in_pkt1));

    // Admission uses the registered count so in_ready never depends on out_ready.
    assign in_ready = (count <= CW'(QDEPTH - 2));
    assign enq_en   = in_valid & {2{in_ready & ~flush}};

    decode_queue #(.QDEPTH(QDEPTH), .PKT_W(PKT_W)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (enq_en),
        .wr_pkt0 (wr_pkt0),
        .wr_pkt1 (wr_pkt1),
        .rd_cnt  (deq_cnt),
        .rd_pkt0 (q_pkt0),
        .rd_pkt1 (q_pkt1),
        .count   (count)
    );

    assign head     = decoded_pkt_t'(q_pkt0);
    assign second   = decoded_pkt_t'(q_pkt1);
    assign out_pkt0 = head;
    assign out_pkt1 = second;

    // Privileged and exception packets must travel alone in slot0.
    assign head_alone   = head.is_privilege   | (|head.is_exception);
    assign second_alone = second.is_privilege | (|second.is_exception);
    assign run_issue    = (state == RUN) & ~flush;

    assign out_valid[0] = run_issue & (count != '0);
    assign out_valid[1] = run_issue & (count >= CW'(2)) & ~head_alone & ~second_alone;

    assign accept0 = out_valid[0] & out_ready[0];
    assign accept1 = out_valid[1] & out_ready[1] & out_ready[0];
    assign deq_cnt = accept1 ? 2'd2 : {1'b0, accept0};

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (accept0 && head.is_privilege) state_nxt = WAIT_PRIV;
            default: if (priv_done) state_nxt = RUN;
        endcase
        if (flush) state_nxt = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    assign serial_busy = (state == WAIT_PRIV);

`ifdef DECODE_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued       <= '0;
            perf_serial_stall <= '0;
        end else begin
            perf_issued       <= perf_issued + 32'(deq_cnt);
            perf_serial_stall <= perf_serial_stall + 32'(serial_busy);
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_decode_issue_ctrl;
    import decode_issue_ctrl_pkg::*;

    localparam int QDEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         priv_done = 1'b0;
    logic [1:0]   in_valid = '0;
    logic [1:0]   out_ready = '0;
    logic [127:0] in_pkt0 = '0;
    logic [127:0] in_pkt1 = '0;
    logic         in_ready, serial_busy;
    logic [1:0]   out_valid;
    logic [127:0] out_pkt0, out_pkt1;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0]  perf_issued, perf_serial_stall;
`endif

    always #5 clk = ~clk;

    decode_issue_ctrl #(.QDEPTH(QDEPTH), .PKT_W(128)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pkt0     (in_pkt0),
        .in_pkt1     (in_pkt1),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pkt0    (out_pkt0),
        .out_pkt1    (out_pkt1),
        .out_ready   (out_ready),
        .priv_done   (priv_done),
        .serial_busy (serial_busy)
`ifdef DECODE_PERF_CNT_EN
        ,
        .perf_issued       (perf_issued),
        .perf_serial_stall (perf_serial_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    decoded_pkt_t mq[$];
    bit m_wait = 1'b0;
    logic [31:0] pc_next = 32'h1c00_0000;

    typedef struct {
        bit         fl;
        bit         pd;
        logic [1:0] iv;
        logic [1:0] ordy;
        bit         priv0;
        logic [1:0] e_ov;
        bit         e_ir;
        bit         e_busy;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic decoded_pkt_t mk_pkt(input logic [31:0] pc, input bit priv, input bit ivld);
        decoded_pkt_t p;
        p = '0;
        p.pc             = pc;
        p.inst           = priv ? 32'h0400_0021 : {7'b0001010, pc[21:2], 5'd4};
        p.aluop          = priv ? 8'h2a : 8'h11;
        p.alusel         = 3'b001;
        p.reg_write_en   = 1'b1;
        p.reg_write_addr = 5'd4;
        p.reg1_read_en   = priv;
        p.reg1_addr      = pc[6:2];
        p.is_privilege   = priv;
        p.csr_we         = priv;
        p.csr_addr       = priv ? 14'h0006 : 14'h0000;
        p.inst_valid     = ivld;
        if (!ivld) p.inst = 32'hffff_ffff;
        return p;
    endfunction

    // Reference model: a plain FIFO of packets plus a "waiting for commit" flag.
    function automatic decoded_pkt_t m_rewrite(input decoded_pkt_t p);
        if (!p.inst_valid) begin
            p.is_exception[2]         = 1'b1;
            p.decoder_exception_cause = EXCEPTION_INE;
            p.reg_write_en            = 1'b0;
            p.aluop                   = ALU_NOP;
            p.alusel                  = ALU_SEL_NOP;
        end
        return p;
    endfunction

    function automatic bit m_solo(input decoded_pkt_t p);
        return p.is_privilege || (p.is_exception != 3'b000);
    endfunction

    function automatic logic [1:0] m_ov();
        logic [1:0] v;
        v = 2'b00;
        if (!flush && !m_wait && mq.size() >= 1) begin
            v[0] = 1'b1;
            if (mq.size() >= 2 && !m_solo(mq[0]) && !m_solo(mq[1])) v[1] = 1'b1;
        end
        return v;
    endfunction

    task automatic check_model();
        logic [127:0] e0, e1;
        e0 = '0;
        e1 = '0;
        if (mq.size() >= 1) e0 = mq[0];
        if (mq.size() >= 2) e1 = mq[1];
        chk("out_valid", out_valid, m_ov());
        chk("in_ready", in_ready, mq.size() <= QDEPTH - 2);
        chk("serial_busy", serial_busy, m_wait);
        chk("out_pkt0", out_pkt0, e0);
        chk("out_pkt1", out_pkt1, e1);
    endtask

    task automatic model_update();
        logic [1:0] v;
        bit ir;
        int ndeq;
        v = m_ov();
        ir = (mq.size() <= QDEPTH - 2);
        ndeq = 0;
        if (flush) begin
            mq.delete();
            m_wait = 1'b0;
            return;
        end
        if (v[0] && out_ready[0]) begin
            ndeq = (v[1] && out_ready[1]) ? 2 : 1;
            if (mq[0].is_privilege) m_wait = 1'b1;
        end else if (m_wait && priv_done) begin
            m_wait = 1'b0;
        end
        repeat (ndeq) void'(mq.pop_front());
        if (ir) begin
            if (in_valid[0]) mq.push_back(m_rewrite(in_pkt0));
            if (in_valid[1]) mq.push_back(m_rewrite(in_pkt1));
        end
    endtask

    task automatic drive(input logic [1:0] iv, input logic [1:0] ordy, input bit fl, input bit pd,
                         input bit p0, input bit v0);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        priv_done = pd;
        in_pkt0   = mk_pkt(pc_next, p0, v0);
        in_pkt1   = mk_pkt(pc_next + 32'd4, 1'b0, 1'b1);
        if (iv[0]) pc_next += 32'd4;
        if (iv[1]) pc_next += 32'd4;
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        decoded_pkt_t o0, o1;

        #3;
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_serial_busy", serial_busy, 1'b0);
        chk("rst_out_pkt0", out_pkt0, '0);
        chk("rst_out_pkt1", out_pkt1, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // {flush, priv_done, in_valid, out_ready, slot0 privileged, exp out_valid, exp in_ready, exp busy}
        tbl[0]  = '{0, 0, 2'b11, 2'b00, 0, 2'b00, 1, 0};
        tbl[1]  = '{0, 0, 2'b11, 2'b00, 0, 2'b11, 1, 0};
        tbl[2]  = '{0, 0, 2'b11, 2'b00, 0, 2'b11, 0, 0};
        tbl[3]  = '{0, 0, 2'b00, 2'b01, 0, 2'b11, 0, 0};
        tbl[4]  = '{0, 0, 2'b00, 2'b01, 0, 2'b11, 0, 0};
        tbl[5]  = '{0, 0, 2'b00, 2'b00, 0, 2'b11, 1, 0};
        tbl[6]  = '{1, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0};
        tbl[7]  = '{0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0};
        tbl[8]  = '{0, 0, 2'b11, 2'b00, 1, 2'b00, 1, 0};
        tbl[9]  = '{0, 0, 2'b01, 2'b00, 0, 2'b01, 1, 0};
        tbl[10] = '{0, 0, 2'b00, 2'b11, 0, 2'b01, 0, 0};
        tbl[11] = '{0, 0, 2'b00, 2'b11, 0, 2'b00, 1, 1};
        tbl[12] = '{0, 0, 2'b00, 2'b11, 0, 2'b00, 1, 1};
        tbl[13] = '{0, 1, 2'b00, 2'b11, 0, 2'b00, 1, 1};
        tbl[14] = '{0, 0, 2'b00, 2'b11, 0, 2'b11, 1, 0};
        tbl[15] = '{0, 0, 2'b00, 2'b11, 0, 2'b00, 1, 0};
        tbl[16] = '{0, 0, 2'b11, 2'b00, 1, 2'b00, 1, 0};
        tbl[17] = '{0, 0, 2'b00, 2'b01, 0, 2'b01, 1, 0};
        tbl[18] = '{1, 1, 2'b11, 2'b00, 0, 2'b00, 1, 1};
        tbl[19] = '{0, 0, 2'b00, 2'b00, 0, 2'b00, 1, 0};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].pd, tbl[i].priv0, 1'b1);
            sample();
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d_serial_busy", i), serial_busy, tbl[i].e_busy);
            advance();
        end

        // Back-to-back pairs with full dispatch acceptance.
        pc_next = 32'h1c00_0000;
        for (int c = 0; c < 6; c++) begin
            drive((c < 4) ? 2'b11 : 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
            sample();
            chk($sformatf("b2b%0d_in_ready", c), in_ready, 1'b1);
            if (c >= 1 && c <= 4) begin
                o0 = out_pkt0;
                o1 = out_pkt1;
                chk($sformatf("b2b%0d_out_valid", c), out_valid, 2'b11);
                chk($sformatf("b2b%0d_pc0", c), o0.pc, 32'h1c00_0000 + 32'(8 * (c - 1)));
                chk($sformatf("b2b%0d_pc1", c), o1.pc, 32'h1c00_0004 + 32'(8 * (c - 1)));
            end
            advance();
        end

        // Undecodable instruction becomes a lone INE packet.
        drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        advance();
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        sample();
        o0 = out_pkt0;
        chk("ine_out_valid", out_valid, 2'b01);
        chk("ine_is_exception2", o0.is_exception[2], 1'b1);
        chk("ine_cause", o0.decoder_exception_cause, EXCEPTION_INE);
        chk("ine_reg_write_en", o0.reg_write_en, 1'b0);
        chk("ine_aluop", o0.aluop, ALU_NOP);
        chk("ine_inst", o0.inst, 32'hffff_ffff);
        advance();
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        sample();
        advance();

        // Asynchronous reset with three entries queued and a privileged op outstanding.
        drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        sample();
        advance();
        drive(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        sample();
        advance();
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        sample();
        chk("pre_rst_busy", serial_busy, 1'b1);
        @(posedge clk);
        #1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 2'b00);
        chk("async_rst_in_ready", in_ready, 1'b1);
        chk("async_rst_serial_busy", serial_busy, 1'b0);
        #1 rst_n = 1'b1;
        mq.delete();
        m_wait = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [1:0] iv;
            decoded_pkt_t r0, r1;
            case ($urandom_range(0, 2))
                0:       iv = 2'b00;
                1:       iv = 2'b01;
                default: iv = 2'b11;
            endcase
            drive(iv, 2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 9) != 0));
            r0 = in_pkt0;
            r1 = in_pkt1;
            if ($urandom_range(0, 19) == 0) r0.is_exception[0] = 1'b1;
            r1.is_privilege = ($urandom_range(0, 6) == 0);
            r1.inst_valid   = ($urandom_range(0, 9) != 0);
            in_pkt0 = r0;
            in_pkt1 = r1;
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
